// File: rtl/nes_input_pkg.sv
// Shared scan-code constants, button indices and decoder types for the NES joypad front end.
package nes_input_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BTN_W  = 8;

  // Prefixes and keyboard control/status bytes
  localparam logic [BYTE_W-1:0] SC_BREAK   = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_EXT     = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_PAUSE   = 8'hE1;
  localparam logic [BYTE_W-1:0] SC_BAT_OK  = 8'hAA;
  localparam logic [BYTE_W-1:0] SC_ACK     = 8'hFA;
  localparam logic [BYTE_W-1:0] SC_RESEND  = 8'hFE;
  localparam logic [BYTE_W-1:0] SC_ECHO    = 8'hEE;

  // Player 1 keys (directions are E0-prefixed arrows)
  localparam logic [BYTE_W-1:0] SC_P1_A      = 8'h22;
  localparam logic [BYTE_W-1:0] SC_P1_B      = 8'h1A;
  localparam logic [BYTE_W-1:0] SC_P1_SELECT = 8'h59;
  localparam logic [BYTE_W-1:0] SC_P1_START  = 8'h5A;
  localparam logic [BYTE_W-1:0] SC_P1_UP     = 8'h75;
  localparam logic [BYTE_W-1:0] SC_P1_DOWN   = 8'h72;
  localparam logic [BYTE_W-1:0] SC_P1_LEFT   = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_P1_RIGHT  = 8'h74;

  // Player 2 keys (all non-extended)
  localparam logic [BYTE_W-1:0] SC_P2_A      = 8'h42;
  localparam logic [BYTE_W-1:0] SC_P2_B      = 8'h3B;
  localparam logic [BYTE_W-1:0] SC_P2_SELECT = 8'h34;
  localparam logic [BYTE_W-1:0] SC_P2_START  = 8'h33;
  localparam logic [BYTE_W-1:0] SC_P2_UP     = 8'h1D;
  localparam logic [BYTE_W-1:0] SC_P2_DOWN   = 8'h1B;
  localparam logic [BYTE_W-1:0] SC_P2_LEFT   = 8'h1C;
  localparam logic [BYTE_W-1:0] SC_P2_RIGHT  = 8'h23;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_e;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_BRK     = 2'd1,
    DEC_EXT     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic hit;
    logic player;  // 0 = port 1, 1 = port 2
    btn_e idx;
  } key_map_t;

  function automatic logic is_ctrl_byte(input logic [BYTE_W-1:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK) || (code == SC_RESEND) ||
           (code == SC_ECHO) || (code == SC_PAUSE);
  endfunction

  // Look up a code in the extended or plain key table
  function automatic key_map_t map_key(input logic [BYTE_W-1:0] code, input logic ext);
    key_map_t m;
    m.hit    = 1'b1;
    m.player = 1'b0;
    m.idx    = BTN_A;
    if (ext) begin
      case (code)
        SC_P1_UP:    m.idx = BTN_UP;
        SC_P1_DOWN:  m.idx = BTN_DOWN;
        SC_P1_LEFT:  m.idx = BTN_LEFT;
        SC_P1_RIGHT: m.idx = BTN_RIGHT;
        default:     m.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_P1_A:      m.idx = BTN_A;
        SC_P1_B:      m.idx = BTN_B;
        SC_P1_SELECT: m.idx = BTN_SELECT;
        SC_P1_START:  m.idx = BTN_START;
        SC_P2_A:      begin m.player = 1'b1; m.idx = BTN_A;      end
        SC_P2_B:      begin m.player = 1'b1; m.idx = BTN_B;      end
        SC_P2_SELECT: begin m.player = 1'b1; m.idx = BTN_SELECT; end
        SC_P2_START:  begin m.player = 1'b1; m.idx = BTN_START;  end
        SC_P2_UP:     begin m.player = 1'b1; m.idx = BTN_UP;     end
        SC_P2_DOWN:   begin m.player = 1'b1; m.idx = BTN_DOWN;   end
        SC_P2_LEFT:   begin m.player = 1'b1; m.idx = BTN_LEFT;   end
        SC_P2_RIGHT:  begin m.player = 1'b1; m.idx = BTN_RIGHT;  end
        default:      m.hit = 1'b0;
      endcase
    end
    return m;
  endfunction

  // Opposing directions held together cancel each other out
  function automatic logic [BTN_W-1:0] mask_opposing(input logic [BTN_W-1:0] b);
    logic [BTN_W-1:0] m;
    m = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      m[BTN_UP]   = 1'b0;
      m[BTN_DOWN] = 1'b0;
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      m[BTN_LEFT]  = 1'b0;
      m[BTN_RIGHT] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/nes_joypad_shift.sv
// One controller-port shift register: parallel reload while strobed, shift-right on reads.
module nes_joypad_shift
  import nes_input_pkg::*;
#(
  parameter bit OPEN_BUS_BIT = 1'b1
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             rd,
  input  logic [BTN_W-1:0] load_val,
  output logic             d_c
);

  logic [BTN_W-1:0] sr_q;

  // Reload has priority so reads during strobe never advance the register
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      sr_q <= '1;
    end else if (load) begin
      sr_q <= load_val;
    end else if (rd) begin
      sr_q <= {OPEN_BUS_BIT, sr_q[BTN_W-1:1]};
    end
  end

  assign d_c = sr_q[0];

endmodule

// File: rtl/nes_joypad_ctrl.sv
// PS/2 scan-code decoder feeding two NES controller ports with $4016/$4017 strobe/read semantics.
module nes_joypad_ctrl
  import nes_input_pkg::*;
#(
  parameter bit BLOCK_OPPOSING = 1'b1,
  parameter bit OPEN_BUS_BIT   = 1'b1
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              kb_valid,
  input  logic [BYTE_W-1:0] kb_data,
  input  logic              strobe_we,
  input  logic              strobe_d,
  input  logic              rd_p1,
  input  logic              rd_p2,
  output logic              d_p1,
  output logic              d_p2,
  output logic [BTN_W-1:0]  buttons_p1,
  output logic [BTN_W-1:0]  buttons_p2
);

  dec_state_e       state_q, state_d;
  logic [BTN_W-1:0] btn_p1_q, btn_p1_d;
  logic [BTN_W-1:0] btn_p2_q, btn_p2_d;
  logic [BTN_W-1:0] btn_p1_m, btn_p2_m;
  logic             strobe_q;
  logic             load_en;
  key_map_t         key_plain, key_ext, key_sel;
  logic             key_hit, key_set;

  assign key_plain = map_key(kb_data, 1'b0);
  assign key_ext   = map_key(kb_data, 1'b1);

  // Decoder state and raw button registers
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q  <= DEC_IDLE;
      btn_p1_q <= '0;
      btn_p2_q <= '0;
    end else begin
      state_q  <= state_d;
      btn_p1_q <= btn_p1_d;
      btn_p2_q <= btn_p2_d;
    end
  end

  // Make/break/extended sequencing
  always_comb begin
    state_d  = state_q;
    btn_p1_d = btn_p1_q;
    btn_p2_d = btn_p2_q;
    key_sel  = key_plain;
    key_hit  = 1'b0;
    key_set  = 1'b0;

    if (kb_valid) begin
      if (is_ctrl_byte(kb_data)) begin
        state_d = DEC_IDLE;
      end else begin
        case (state_q)
          DEC_IDLE: begin
            if (kb_data == SC_BREAK) begin
              state_d = DEC_BRK;
            end else if (kb_data == SC_EXT) begin
              state_d = DEC_EXT;
            end else begin
              key_hit = key_plain.hit;
              key_set = 1'b1;
            end
          end
          DEC_BRK: begin
            state_d = DEC_IDLE;
            key_hit = key_plain.hit;
          end
          DEC_EXT: begin
            if (kb_data == SC_BREAK) begin
              state_d = DEC_EXT_BRK;
            end else begin
              state_d = DEC_IDLE;
              key_sel = key_ext;
              key_hit = key_ext.hit;
              key_set = 1'b1;
            end
          end
          DEC_EXT_BRK: begin
            state_d = DEC_IDLE;
            key_sel = key_ext;
            key_hit = key_ext.hit;
          end
          default: state_d = DEC_IDLE;
        endcase
      end
    end

    if (key_hit) begin
      if (key_sel.player) btn_p2_d[key_sel.idx] = key_set;
      else                btn_p1_d[key_sel.idx] = key_set;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n)       strobe_q <= 1'b0;
    else if (strobe_we) strobe_q <= strobe_d;
  end

  assign btn_p1_m   = BLOCK_OPPOSING ? mask_opposing(btn_p1_q) : btn_p1_q;
  assign btn_p2_m   = BLOCK_OPPOSING ? mask_opposing(btn_p2_q) : btn_p2_q;
  assign buttons_p1 = btn_p1_m;
  assign buttons_p2 = btn_p2_m;

  // A rising strobe write reloads on its own edge; a falling one takes the final reload
  assign load_en = strobe_q | (strobe_we & strobe_d);

  nes_joypad_shift #(.OPEN_BUS_BIT(OPEN_BUS_BIT)) u_shift_p1 (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .load     (load_en),
    .rd       (rd_p1),
    .load_val (btn_p1_m),
    .d_c      (d_p1)
  );

  nes_joypad_shift #(.OPEN_BUS_BIT(OPEN_BUS_BIT)) u_shift_p2 (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .load     (load_en),
    .rd       (rd_p2),
    .load_val (btn_p2_m),
    .d_c      (d_p2)
  );

endmodule
